wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Arbiter for the single register-file write port, shared between the pipeline writeback stage and the multi-cycle multiply/divide unit (MDU). Sits between the writeback stage's write-data output and the register file. Buffers up to two MDU results. Gives the pipeline priority, and forces a one-cycle pipeline stall when a buffered MDU result has waited too long.

## Interface
Parameters:
- STARVE_LIMIT, 4, blocked cycles (range 1..15) a buffered MDU result tolerates before a forced drain

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- reset_i  in  1  synchronous, active-high reset
- pipe_wr_en_i  in  1  writeback stage requests a register write
- pipe_rd_i  in  5  writeback destination register
- pipe_data_i  in  32  writeback data (selected write_data_reg_o)
- mdu_valid_i  in  1  MDU result valid
- mdu_rd_i  in  5  MDU destination register
- mdu_data_i  in  32  MDU result
- mdu_ready_o  out  1  buffer can accept an MDU result
- rf_we_o  out  1  register-file write enable (registered)
- rf_waddr_o  out  5  register-file write address (registered)
- rf_wdata_o  out  32  register-file write data (registered)
- pipe_stall_o  out  1  freeze the pipeline this cycle
- pend_count_o  out  2  buffered MDU results (0..2)

## Operation
- 2-entry FIFO for MDU results. Push when mdu_valid_i && mdu_ready_o. mdu_ready_o = (count < 2), combinational.
- A pipeline claim is pipe_wr_en_i && pipe_rd_i != 0 && state != FORCE. A write with rd = 0 never claims the port.
- Port selection each cycle:
  - A pipeline claim wins.
  - Otherwise, if the FIFO is non-empty, the head is popped and selected.
  - Otherwise, no write.
- The selection is registered onto rf_we_o/rf_waddr_o/rf_wdata_o at the next edge. An MDU entry with rd = 0 is popped but drives rf_we_o = 0.
- Push and pop in the same cycle are legal when count is 1; count stays 1. A pushed entry is not selectable in its push cycle.
- FSM, pipe_stall_o = (state == FORCE):
  - IDLE: FIFO empty. Go to WAIT on push.
  - WAIT: FIFO non-empty.
    - starve_cnt increments on each cycle the head is blocked by a pipeline claim.
    - starve_cnt clears on each pop.
    - On the edge where starve_cnt would reach STARVE_LIMIT, go to FORCE instead.
    - Go to IDLE when a pop empties the FIFO with no push.
  - FORCE: lasts exactly one cycle.
    - The pipeline claim is ignored; the stalled writeback stage re-presents its write next cycle.
    - The head is popped and starve_cnt clears.
    - Next state is WAIT if the FIFO is still non-empty, else IDLE.
- Reset mid-operation: the FIFO is flushed and buffered MDU results are discarded. The MDU re-issues after a pipeline flush.

## Timing
- Reset values:
  - rf_we_o = 0, rf_waddr_o = 0, rf_wdata_o = 0
  - pipe_stall_o = 0, pend_count_o = 0, state = IDLE, starve_cnt = 0
  - mdu_ready_o = 1 in the first cycle after reset deasserts
- Pipeline write latency: claim in cycle N → rf_we_o = 1 in cycle N+1.
- MDU write latency, uncontended: push in cycle N → pop in N+1 → rf_we_o = 1 in N+2.
- Forced drain: after STARVE_LIMIT consecutive blocked cycles, the next cycle is FORCE. pipe_stall_o is high for exactly that cycle, and the MDU write appears on rf_* the cycle after.
- pend_count_o and mdu_ready_o reflect the registered count. Neither is asserted during reset.

## Configuration
- WB_ARB_STARVE_GUARD_EN defined: the FORCE state and starve_cnt exist, and behaviour is as above.
- Undefined:
  - No FORCE state and no starve_cnt.
  - pipe_stall_o is tied 0.
  - The pipeline always wins, so the MDU drains only in cycles without a pipeline claim and may starve indefinitely.
  - STARVE_LIMIT is ignored.

## Test plan
- Pipeline only: pipe_wr_en_i = 1, rd = 5, data = 0xDEADBEEF in cycle N → rf_we_o = 1, rf_waddr_o = 5, rf_wdata_o = 0xDEADBEEF in N+1; MDU idle.
- MDU only: push rd = 7, data = 0x12345678 in N, no pipeline claims → pend_count_o = 1 in N+1, rf_we_o = 1 with rd 7 / 0x12345678 in N+2, pend_count_o = 0.
- Conflict and rd = 0 gap:
  - Pipeline write rd = 3 and MDU push rd = 9 in cycle N.
  - Pipeline write rd = 4 in N+1, then pipe_rd_i = 0 in N+2.
  - Required: rd 3 written in N+1, rd 4 in N+2, rd 9 in N+3.
- Full FIFO: MDU valid for 3 consecutive cycles with a pipeline claim every cycle → two pushes accepted, mdu_ready_o = 0 and pend_count_o = 2 after the second, third held until ready.
- Starvation, macro defined, STARVE_LIMIT = 4: one buffered entry and a pipeline claim every cycle → 4 blocked cycles, then pipe_stall_o = 1 for one cycle, MDU write on rf_* next cycle, pipeline write in the FORCE cycle not performed. Same stimulus with the macro undefined → pipe_stall_o stays 0 and the entry stays pending.
- Reset with pend_count_o = 2 → next cycle rf_we_o = 0, pend_count_o = 0, pipe_stall_o = 0, and mdu_ready_o = 1 after release.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// Register-file write-port bundle: writeback claim, MDU result handshake, RF write side.
// No storage of its own; latency is set by the arbiter behind the slave modport.
// MDU side is valid/ready: a result moves only when mdu_valid_i && mdu_ready_o.
interface wb_port_arbiter_if;
  logic        pipe_wr_en_i;
  logic [4:0]  pipe_rd_i;
  logic [31:0] pipe_data_i;
  logic        mdu_valid_i;
  logic [4:0]  mdu_rd_i;
  logic [31:0] mdu_data_i;
  logic        mdu_ready_o;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        pipe_stall_o;
  logic [1:0]  pend_count_o;

  // Environment side: drives writeback and MDU requests, observes the RF write.
  modport master (
    output pipe_wr_en_i, pipe_rd_i, pipe_data_i,
    output mdu_valid_i, mdu_rd_i, mdu_data_i,
    input  mdu_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, pipe_stall_o, pend_count_o
  );

  // Arbiter side.
  modport slave (
    input  pipe_wr_en_i, pipe_rd_i, pipe_data_i,
    input  mdu_valid_i, mdu_rd_i, mdu_data_i,
    output mdu_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, pipe_stall_o, pend_count_o
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the single RF write port between writeback (priority) and a 2-entry MDU result buffer.
// Latency: pipeline claim -> rf_* next cycle; uncontended MDU push -> rf_* two cycles later.
// Backpressure: mdu_ready_o drops when both buffer slots are full; with WB_ARB_STARVE_GUARD_EN
// defined, a starved MDU head forces a one-cycle pipe_stall_o to drain itself.

// Small generic synchronous FIFO.
// Latency: a pushed word is visible on dout the cycle after the push.
// Backpressure: caller must not push when full or pop when empty.
module wb_arb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Storage needs no reset: count and pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout = mem[rd_ptr];
endmodule

module wb_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk_i,
  input  logic                reset_i,
  wb_port_arbiter_if.slave    bus
);
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_range
    $error("wb_port_arbiter: STARVE_LIMIT must be within 1..15");
  end

`ifdef WB_ARB_STARVE_GUARD_EN
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_FORCE} state_t;
  localparam logic [3:0] LIMIT_M1 = 4'(STARVE_LIMIT - 1);
  logic [3:0] starve_cnt;
  logic       stall_q;
`else
  typedef enum logic {ST_IDLE, ST_WAIT} state_t;
`endif

  state_t      state;
  logic [1:0]  count;
  logic [36:0] head;
  logic [4:0]  head_rd;
  logic [31:0] head_data;
  logic        ready;
  logic        push;
  logic        pop;
  logic        claim;
  logic        blocked;
  logic        nonempty;

  // Ready and occupancy are held low during reset so nothing is pushed into a flushing buffer.
  assign ready    = !reset_i && (count != 2'd2);
  assign push     = bus.mdu_valid_i && ready;
  assign nonempty = (count != 2'd0);

`ifdef WB_ARB_STARVE_GUARD_EN
  // During the forced drain the writeback stage is frozen and re-presents its write later.
  assign claim = bus.pipe_wr_en_i && (bus.pipe_rd_i != 5'd0) && (state != ST_FORCE);
`else
  assign claim = bus.pipe_wr_en_i && (bus.pipe_rd_i != 5'd0);
`endif

  assign pop     = !claim && nonempty;
  assign blocked = claim && nonempty;

  wb_arb_fifo #(.WIDTH(37), .DEPTH(2)) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push    (push),
    .pop     (pop),
    .din     ({bus.mdu_rd_i, bus.mdu_data_i}),
    .dout    (head),
    .count   (count)
  );

  assign {head_rd, head_data} = head;

  // Register the winning source onto the RF write port; rd = 0 entries drain without writing.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bus.rf_we_o    <= 1'b0;
      bus.rf_waddr_o <= 5'd0;
      bus.rf_wdata_o <= 32'd0;
    end else if (claim) begin
      bus.rf_we_o    <= 1'b1;
      bus.rf_waddr_o <= bus.pipe_rd_i;
      bus.rf_wdata_o <= bus.pipe_data_i;
    end else if (pop) begin
      bus.rf_we_o    <= (head_rd != 5'd0);
      bus.rf_waddr_o <= head_rd;
      bus.rf_wdata_o <= head_data;
    end else begin
      bus.rf_we_o    <= 1'b0;
    end
  end

`ifdef WB_ARB_STARVE_GUARD_EN
  // Buffer-occupancy FSM with starvation counter; stall_q is high exactly while in FORCE.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= ST_IDLE;
      starve_cnt <= 4'd0;
      stall_q    <= 1'b0;
    end else begin
      stall_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (push) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (pop) begin
            starve_cnt <= 4'd0;
            if (count == 2'd1 && !push) state <= ST_IDLE;
          end else if (blocked) begin
            if (starve_cnt == LIMIT_M1) begin
              state   <= ST_FORCE;
              stall_q <= 1'b1;
            end else begin
              starve_cnt <= starve_cnt + 4'd1;
            end
          end
        end
        ST_FORCE: begin
          starve_cnt <= 4'd0;
          state      <= (count == 2'd1 && !push) ? ST_IDLE : ST_WAIT;
        end
        default: begin
          state      <= ST_IDLE;
          starve_cnt <= 4'd0;
        end
      endcase
    end
  end

  assign bus.pipe_stall_o = stall_q;
`else
  // Buffer-occupancy FSM; without the guard the pipeline always wins and nothing forces a drain.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (push) state <= ST_WAIT;
        ST_WAIT: if (pop && count == 2'd1 && !push) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.pipe_stall_o = 1'b0;
`endif

  assign bus.mdu_ready_o  = ready;
  assign bus.pend_count_o = reset_i ? 2'd0 : count;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios then random traffic, all checked against a queue model.
// Inputs change #1 after each rising edge; outputs are checked #1 after the edge.
// The model follows the port rules: pipeline first, else FIFO head, forced drain after LIMIT blocked cycles.
module tb_wb_port_arbiter;
  localparam int LIMIT = 4;
`ifdef WB_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_i;
  always #5 clk = ~clk;

  wb_port_arbiter_if bus ();

  wb_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .bus     (bus)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  int          checks = 0;
  int          errors = 0;
  ent_t        q[$];
  bit          m_force = 1'b0;
  int          m_run = 0;
  bit          e_we = 1'b0;
  logic [4:0]  e_addr = '0;
  logic [31:0] e_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, advance the model, then compare every output.
  task automatic step(input bit r, input bit pw, input logic [4:0] prd, input logic [31:0] pd,
                      input bit mv, input logic [4:0] mrd, input logic [31:0] md, output bit pushed);
    bit   exp_rdy;
    bit   claim;
    bit   nonempty;
    ent_t h;
    bit   new_force;
    reset_i          = r;
    bus.pipe_wr_en_i = pw;
    bus.pipe_rd_i    = prd;
    bus.pipe_data_i  = pd;
    bus.mdu_valid_i  = mv;
    bus.mdu_rd_i     = mrd;
    bus.mdu_data_i   = md;
    #1;
    exp_rdy = !r && (q.size() < 2);
    chk("ready_pre", 32'(bus.mdu_ready_o), 32'(exp_rdy));
    pushed = mv && exp_rdy;
    if (r) begin
      q.delete();
      m_force = 1'b0;
      m_run   = 0;
      e_we    = 1'b0;
      e_addr  = '0;
      e_data  = '0;
    end else begin
      claim     = pw && (prd != 5'd0) && !(GUARD && m_force);
      nonempty  = (q.size() > 0);
      new_force = 1'b0;
      if (claim) begin
        e_we = 1'b1; e_addr = prd; e_data = pd;
      end else if (nonempty) begin
        h = q.pop_front();
        e_we = (h.rd != 5'd0); e_addr = h.rd; e_data = h.data;
      end else begin
        e_we = 1'b0;
      end
      if (!claim && nonempty) m_run = 0;
      else if (claim && nonempty) begin
        if (GUARD && (m_run + 1 >= LIMIT)) begin
          new_force = 1'b1;
          m_run     = 0;
        end else begin
          m_run++;
        end
      end
      if (pushed) q.push_back('{rd: mrd, data: md});
      m_force = new_force;
    end
    @(posedge clk);
    #1;
    chk("rf_we", 32'(bus.rf_we_o), 32'(e_we));
    if (e_we) begin
      chk("rf_waddr", 32'(bus.rf_waddr_o), 32'(e_addr));
      chk("rf_wdata", bus.rf_wdata_o, e_data);
    end
    chk("pipe_stall", 32'(bus.pipe_stall_o), 32'(m_force));
    chk("pend_count", 32'(bus.pend_count_o), 32'(q.size()));
    chk("ready_post", 32'(bus.mdu_ready_o), 32'(!r && (q.size() < 2)));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit p;
    int stall_cnt;
    int stall_idx;
    int mdu_idx;
    int tries;

    // Reset state.
    step(1, 0, 0, 0, 0, 0, 0, p);
    step(1, 0, 0, 0, 0, 0, 0, p);
    chk("reset_waddr", 32'(bus.rf_waddr_o), 32'd0);
    chk("reset_wdata", bus.rf_wdata_o, 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, p);
    chk("ready_after_reset", 32'(bus.mdu_ready_o), 32'd1);

    // Pipeline only.
    step(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, p);
    chk("pipe_only_we", 32'(bus.rf_we_o), 32'd1);
    chk("pipe_only_addr", 32'(bus.rf_waddr_o), 32'd5);
    chk("pipe_only_data", bus.rf_wdata_o, 32'hDEADBEEF);

    // MDU only.
    step(0, 0, 0, 0, 1, 5'd7, 32'h12345678, p);
    chk("mdu_only_pend1", 32'(bus.pend_count_o), 32'd1);
    chk("mdu_only_no_we", 32'(bus.rf_we_o), 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, p);
    chk("mdu_only_addr", 32'(bus.rf_waddr_o), 32'd7);
    chk("mdu_only_data", bus.rf_wdata_o, 32'h12345678);
    chk("mdu_only_pend0", 32'(bus.pend_count_o), 32'd0);

    // Conflict followed by an rd = 0 gap.
    step(0, 1, 5'd3, 32'hA0A0_0003, 1, 5'd9, 32'h9999_0009, p);
    chk("conflict_n1_addr", 32'(bus.rf_waddr_o), 32'd3);
    step(0, 1, 5'd4, 32'hA0A0_0004, 0, 0, 0, p);
    chk("conflict_n2_addr", 32'(bus.rf_waddr_o), 32'd4);
    step(0, 1, 5'd0, 32'hFFFF_FFFF, 0, 0, 0, p);
    chk("conflict_n3_we", 32'(bus.rf_we_o), 32'd1);
    chk("conflict_n3_addr", 32'(bus.rf_waddr_o), 32'd9);
    chk("conflict_n3_data", bus.rf_wdata_o, 32'h9999_0009);

    // Full FIFO: three back-to-back MDU results under constant pipeline claims.
    step(0, 1, 5'd1, 32'h1, 1, 5'd10, 32'hA, p);
    step(0, 1, 5'd1, 32'h2, 1, 5'd11, 32'hB, p);
    chk("full_pend2", 32'(bus.pend_count_o), 32'd2);
    chk("full_not_ready", 32'(bus.mdu_ready_o), 32'd0);
    step(0, 1, 5'd1, 32'h3, 1, 5'd12, 32'hC, p);
    chk("full_third_refused", 32'(p), 32'd0);
    tries = 0;
    while (!p && tries < 8) begin
      step(0, 0, 0, 0, 1, 5'd12, 32'hC, p);
      tries++;
    end
    chk("full_third_accepted", 32'(p), 32'd1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, p);
    chk("full_drained", 32'(bus.pend_count_o), 32'd0);

    // Starvation: one buffered entry, pipeline claims every cycle.
    step(0, 1, 5'd2, 32'h22, 1, 5'd13, 32'hD00D, p);
    stall_cnt = 0;
    stall_idx = -1;
    mdu_idx   = -1;
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 5'd2, 32'h22, 0, 0, 0, p);
      if (bus.pipe_stall_o) begin
        stall_cnt++;
        stall_idx = i;
      end
      if (bus.rf_we_o && bus.rf_waddr_o == 5'd13) mdu_idx = i;
    end
    chk("starve_stall_cycles", 32'(stall_cnt), GUARD ? 32'd1 : 32'd0);
    chk("starve_stall_index", 32'(stall_idx), GUARD ? 32'd3 : 32'hFFFF_FFFF);
    chk("starve_mdu_index", 32'(mdu_idx), GUARD ? 32'd4 : 32'hFFFF_FFFF);
    chk("starve_pending", 32'(bus.pend_count_o), GUARD ? 32'd0 : 32'd1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, p);

    // Reset while two results are buffered.
    step(0, 1, 5'd6, 32'h6, 1, 5'd14, 32'hE, p);
    step(0, 1, 5'd6, 32'h6, 1, 5'd15, 32'hF, p);
    chk("pre_reset_pend2", 32'(bus.pend_count_o), 32'd2);
    step(1, 1, 5'd6, 32'h6, 0, 0, 0, p);
    chk("mid_reset_we", 32'(bus.rf_we_o), 32'd0);
    chk("mid_reset_pend", 32'(bus.pend_count_o), 32'd0);
    chk("mid_reset_stall", 32'(bus.pipe_stall_o), 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, p);
    chk("post_reset_ready", 32'(bus.mdu_ready_o), 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bit          r;
      bit          pw;
      bit          mv;
      logic [4:0]  prd;
      logic [4:0]  mrd;
      r   = ($urandom_range(0, 79) == 0);
      pw  = ($urandom_range(0, 9) < 7);
      prd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
      mv  = ($urandom_range(0, 1) == 1);
      mrd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      step(r, pw, prd, $urandom, mv, mrd, $urandom, p);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
